// File: rtl/divider.sv
// Multicycle radix-2 restoring integer divider, signed or unsigned, fixed WIDTH+2 cycle latency.
// Shares the level-held start / one-cycle end handshake used by the Booth multiplier.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_start_i,
  input  logic             div_signed_i,
  input  logic [WIDTH-1:0] div_opd1_i,
  input  logic [WIDTH-1:0] div_opd2_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_end_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operands captured at the accepting edge
  logic [WIDTH-1:0] r_opd1;
  logic [WIDTH-1:0] r_opd2;
  logic             r_signed;

  // Iteration datapath
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_dsr;
  logic [WIDTH:0]   r_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_end;

  // Per-state strobes; each requires the request to still be held
  logic w_load;
  logic w_prep;
  logic w_calc;
  logic w_fix;

  logic [WIDTH:0]   w_ext1;
  logic [WIDTH:0]   w_ext2;
  logic [WIDTH:0]   w_abs1;
  logic [WIDTH:0]   w_abs2;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_next;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_quot_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; dropping the request in PREP/CALC/FIX aborts to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = div_start_i ? S_PREP : S_IDLE;
      S_PREP:  w_state_next = div_start_i ? S_CALC : S_IDLE;
      S_CALC: begin
        if (!div_start_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == LAST_ITER) begin
          w_state_next = S_FIX;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_FIX:   w_state_next = div_start_i ? S_WAIT : S_IDLE;
      S_WAIT:  w_state_next = div_start_i ? S_WAIT : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output/strobe decode
  always_comb begin
    w_load = 1'b0;
    w_prep = 1'b0;
    w_calc = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = div_start_i;
      S_PREP:  w_prep = div_start_i;
      S_CALC:  w_calc = div_start_i;
      S_FIX:   w_fix  = div_start_i;
      default: ;
    endcase
  end

  // WIDTH+1-bit magnitudes so that |most-negative| is representable
  assign w_ext1 = {r_signed & r_opd1[WIDTH-1], r_opd1};
  assign w_ext2 = {r_signed & r_opd2[WIDTH-1], r_opd2};
  assign w_abs1 = w_ext1[WIDTH] ? -w_ext1 : w_ext1;
  assign w_abs2 = w_ext2[WIDTH] ? -w_ext2 : w_ext2;

  // One restoring step: the borrow out of the extended difference rejects the subtraction
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dsr};
  assign w_qbit     = ~w_diff[WIDTH+1];
  assign w_rem_next = w_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

  assign w_div_zero = (r_dsr == '0);
  assign w_quot_fix = w_div_zero ? {WIDTH{1'b1}} : (r_qneg ? -r_dvd : r_dvd);
  assign w_rem_fix  = w_div_zero ? r_opd1 : (r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_opd1      <= '0;
      r_opd2      <= '0;
      r_signed    <= 1'b0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_end       <= 1'b0;
    end else begin
      r_end <= w_fix;
      if (w_load) begin
        r_opd1   <= div_opd1_i;
        r_opd2   <= div_opd2_i;
        r_signed <= div_signed_i;
      end
      if (w_prep) begin
        r_dvd  <= w_abs1[WIDTH-1:0];
        r_dsr  <= w_abs2;
        // The magnitude's top bit is always zero; it seeds the cleared partial remainder
        r_rem  <= {{WIDTH{1'b0}}, w_abs1[WIDTH]};
        r_qneg <= w_ext1[WIDTH] ^ w_ext2[WIDTH];
        r_rneg <= w_ext1[WIDTH];
        r_cnt  <= '0;
      end
      if (w_calc) begin
        r_rem <= w_rem_next;
        r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fix) begin
        r_quotient  <= w_quot_fix;
        r_remainder <= w_rem_fix;
      end
    end
  end

  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign div_end_o   = r_end;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed corner cases plus random operands
// checked against a plain-arithmetic reference model.
module tb_divider;
  localparam int W = 32;
  localparam int LATENCY = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] opd1;
  logic [W-1:0] opd2;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dend;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  always #5 clk = ~clk;

  divider #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .div_start_i  (start),
    .div_signed_i (sgn),
    .div_opd1_i   (opd1),
    .div_opd2_i   (opd2),
    .quotient_o   (q),
    .remainder_o  (r),
    .div_end_o    (dend)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: truncating division, remainder takes dividend sign, fixed corner results
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] eq, output logic [W-1:0] er);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      eq = '1;
      er = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      eq = 32'h8000_0000;
      er = '0;
    end else if (s) begin
      eq = sa / sb;
      er = sa % sb;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endfunction

  // Drop start for one cycle, present operands, wait for the accepting edge, then scramble inputs
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opd1  = a;
    opd2  = b;
    sgn   = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opd1 = $urandom;
    opd2 = $urandom;
    sgn  = ~s;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int hold, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    int k;
    bit seen;
    model(a, b, s, eq, er);
    issue(a, b, s);
    k = 0;
    seen = 0;
    for (int e = 1; e <= LATENCY + 6 && !seen; e++) begin
      @(posedge clk);
      #1;
      if (dend === 1'b1) begin
        seen = 1;
        k = e;
      end
    end
    n_vec++;
    if (!seen || k != LATENCY) begin
      n_err++;
      $display("FAIL %s latency: got edge %0d (seen=%0d) expected %0d", tag, k, seen, LATENCY);
    end
    n_vec++;
    if (q !== eq) begin
      n_err++;
      $display("FAIL %s quotient: got %h expected %h", tag, q, eq);
    end
    n_vec++;
    if (r !== er) begin
      n_err++;
      $display("FAIL %s remainder: got %h expected %h", tag, r, er);
    end
    $display("op %s: a=%h b=%h signed=%0d -> q=%h r=%h (exp %h %h) at edge %0d",
             tag, a, b, s, q, r, eq, er, k);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (dend !== 1'b0 || q !== eq || r !== er) begin
        n_err++;
        $display("FAIL %s hold[%0d]: got end=%b q=%h r=%h expected end=0 q=%h r=%h",
                 tag, i, dend, q, r, eq, er);
      end
    end
    last_q = eq;
    last_r = er;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    opd1  = '0;
    opd2  = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (q !== '0) begin
      n_err++;
      $display("FAIL reset quotient: got %h expected 0", q);
    end
    n_vec++;
    if (r !== '0) begin
      n_err++;
      $display("FAIL reset remainder: got %h expected 0", r);
    end
    n_vec++;
    if (dend !== 1'b0) begin
      n_err++;
      $display("FAIL reset end: got %b expected 0", dend);
    end
    $display("reset: q=%h r=%h end=%b", q, r, dend);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    run_op(32'd100, 32'd7, 1'b0, 6, "u100/7");
  endtask

  task automatic test_signed;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1, "s-7/2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, "s7/-2");
    run_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1, "s-7/-2");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1, "uFFFFFFF9/2");
  endtask

  task automatic test_boundary;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1, "s_overflow");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1, "umax/1");
    run_op(32'h1234_5678, 32'd0, 1'b0, 1, "u_divzero");
    run_op(32'h1234_5678, 32'd0, 1'b1, 1, "s_divzero");
    run_op(32'h8000_0000, 32'd0, 1'b1, 1, "s_neg_divzero");
    run_op(32'h8000_0000, 32'd1, 1'b1, 1, "s_min/1");
  endtask

  task automatic test_abort;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < LATENCY + 8; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (dend !== 1'b0 || q !== last_q || r !== last_r) begin
        n_err++;
        $display("FAIL abort[%0d]: got end=%b q=%h r=%h expected end=0 q=%h r=%h",
                 i, dend, q, r, last_q, last_r);
      end
    end
    $display("abort: outputs held q=%h r=%h", q, r);
    run_op(32'd9, 32'd4, 1'b0, 1, "after_abort_9/4");
  endtask

  task automatic test_reset_mid;
    issue(32'd123456, 32'd789, 1'b0);
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (q !== '0 || r !== '0 || dend !== 1'b0) begin
      n_err++;
      $display("FAIL midreset: got q=%h r=%h end=%b expected all 0", q, r, dend);
    end
    $display("midreset: q=%h r=%h end=%b", q, r, dend);
    @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    last_r = '0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (dend !== 1'b0 || q !== '0 || r !== '0) begin
        n_err++;
        $display("FAIL midreset_idle[%0d]: got end=%b q=%h r=%h expected 0", i, dend, q, r);
      end
    end
    run_op(32'd77, 32'd10, 1'b0, 1, "after_reset_77/10");
  endtask

  task automatic test_back_to_back;
    run_op(32'd1234, 32'd11, 1'b0, LATENCY + 6, "hold_long");
    run_op(32'd50, 32'd5, 1'b0, 1, "b2b_50/5");
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 1, "b2b_s-100/7");
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = $urandom;
        default: b = -W'($urandom_range(1, 100));
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, 1, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Multicycle iterative integer divider for the execute stage; companion to the Booth multiplier.
- Uses the same level-held start / one-cycle end handshake, so the EXE controller drives both units identically.
- Computes the quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, signed or unsigned, with a fixed latency independent of operand values.
- Uses a radix-2 non-restoring or restoring algorithm, one quotient bit per cycle.

Parameters:
WIDTH, 32, operand/result width (equals `RegW)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
div_start_i  input  1  level request; held high by EXE until div_end_o, dropped to abort
div_signed_i  input  1  1 = two's-complement divide, 0 = unsigned; sampled with operands
div_opd1_i  input  WIDTH  dividend
div_opd2_i  input  WIDTH  divisor
quotient_o  output  WIDTH  quotient, registered
remainder_o  output  WIDTH  remainder, registered
div_end_o  output  1  one-cycle done pulse, registered

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, iteration counter=0, quotient_o=0, remainder_o=0, div_end_o=0. Reset overrides every other condition, including mid-operation.
- States: IDLE, PREP, CALC, FIX, WAIT.
- IDLE: when div_start_i=1 at an edge, latch div_opd1_i, div_opd2_i and div_signed_i; next state PREP. Operand changes after this edge are ignored.
- PREP (1 cycle):
  - Signed mode: take absolute values; record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
  - Unsigned mode: use operands as-is; both signs = 0.
  - Clear the partial remainder; counter=0; next state CALC.
- CALC (exactly WIDTH cycles): each cycle produces one quotient bit, MSB first, and increments the counter. After the WIDTH-th iteration, next state FIX.
- FIX (1 cycle):
  - Apply the remainder correction step if non-restoring.
  - Negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Write quotient_o and remainder_o; set div_end_o=1; next state WAIT.
- WAIT:
  - div_end_o returns to 0 after exactly one cycle.
  - Stay in WAIT while div_start_i=1; go to IDLE when div_start_i=0. This prevents double issue while EXE still holds the request.
- Latency: div_end_o is high in the cycle following the (WIDTH+2)-th rising edge after the accepting edge, i.e. 34 edges for WIDTH=32, for all operand values.
- Abort: div_start_i=0 sampled in PREP, CALC or FIX → next state IDLE. div_end_o stays 0; quotient_o and remainder_o keep their previous values.
- Output stability: quotient_o and remainder_o change only in FIX or on reset. They hold their values until the next completed operation.
- Result rules:
  - Remainder has the sign of the dividend; quotient truncates toward zero.
  - Divide by zero, any mode: quotient_o = all ones; remainder_o = dividend unchanged. Same latency as a normal divide; no exception signalled.
  - Signed overflow (most-negative / -1): quotient_o = most-negative value (0x80000000); remainder_o=0.
  - Absolute-value datapath is WIDTH+1 bits so that |0x80000000| is exact.

Test Plan:
- Unsigned, opd1=100, opd2=7, start held → div_end_o pulses exactly 34 cycles after accept for one cycle; quotient_o=14, remainder_o=2; outputs stable while start stays high; no second pulse.
- Signed sign combinations:
  - -7/2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 7/-2 → q=0xFFFFFFFD, r=1.
  - -7/-2 → q=3, r=0xFFFFFFFF.
  - Same bits unsigned: 0xFFFFFFF9/2 → q=0x7FFFFFFC, r=1.
- Boundaries:
  - Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
  - Divide by zero, 0x12345678/0 in both modes → q=0xFFFFFFFF, r=0x12345678, at the normal latency.
- Abort: drop start at cycle 10 of CALC → no div_end_o; outputs keep the prior result. Re-raise start with 9/4 → q=2, r=1 at full latency.
- Reset mid-CALC: assert rst_i for 1 cycle at cycle 20 → all outputs 0 next cycle, state IDLE. A new request then completes normally.
- Back-to-back: after a pulse, drop start for 1 cycle, then issue 50/5 → q=10, r=0. Start held continuously across WAIT must not begin a new operation.
